cpu_trace_buffer: RTL and testbench
===================================

CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 64: entries per channel; power of two, at least 4.
REQ-002 Parameter DATA_W, default 32: width of each channel sample.
REQ-003 Parameter CH, default 3: channel count; channel 0 is the PC, for example pc, inst, writeback.
REQ-004 Parameter POST_TRIG, default 16: samples captured after the trigger sample; 0 <= POST_TRIG <= DEPTH-1.
REQ-005 Port I_clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 Port I_rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port I_arm, input, 1 bit: single-cycle pulse that starts a capture.
REQ-008 Port I_valid, input, 1 bit: the current I_ch_data is a retired-instruction sample.
REQ-009 Port I_ch_data, input, CH*DATA_W bits: channel c occupies bits [c*DATA_W +: DATA_W].
REQ-010 Port I_trig_en, input, 1 bit: enables the PC-match trigger.
REQ-011 Port I_trig_pc, input, DATA_W bits: PC match value.
REQ-012 Port I_force_trig, input, 1 bit: unconditional trigger.
REQ-013 Port I_rd_addr, input, log2(DEPTH) bits: readout index; 0 is the oldest stored sample.
REQ-014 Port I_rd_ch, input, max(1,clog2(CH)) bits: readout channel select.
REQ-015 Port O_rd_data, output, DATA_W bits: registered readout data.
REQ-016 Port O_state, output, 2 bits: 0 IDLE, 1 ARMED, 2 POST, 3 DONE.
REQ-017 Port O_count, output, log2(DEPTH)+1 bits: number of valid entries, saturating at DEPTH.
REQ-018 Port O_trig_pos, output, log2(DEPTH) bits: readout index of the trigger sample; valid in DONE.
REQ-019 Port O_done, output, 1 bit: high while in DONE.

Function
REQ-020 The FSM SHALL transition IDLE->ARMED on I_arm and DONE->ARMED on I_arm; I_arm SHALL be ignored in ARMED and POST.
REQ-021 Entry to ARMED SHALL clear the write pointer, O_count and post counter; the sample presented in the arm cycle SHALL NOT be captured.
REQ-022 In ARMED and POST, each cycle with I_valid=1 SHALL write all CH channels at the write pointer, increment it modulo DEPTH, and increment O_count up to DEPTH; I_valid=0 cycles SHALL write nothing.
REQ-023 A trigger SHALL be defined as I_valid & (I_force_trig | (I_trig_en & channel0 == I_trig_pc)) while in ARMED.
REQ-024 On a trigger the sample SHALL be stored and its physical index latched; the FSM SHALL go to POST, or directly to DONE when POST_TRIG=0.
REQ-025 In POST the FSM SHALL count stored samples and go to DONE in the cycle the POST_TRIG-th post sample is stored; triggers in POST SHALL be ignored.
REQ-026 In IDLE and DONE no write SHALL occur and buffer contents SHALL be held.
REQ-027 Readout index mapping:
- when O_count < DEPTH, physical index = I_rd_addr;
- otherwise, physical index = (write pointer + I_rd_addr) mod DEPTH.
REQ-028 Addresses >= O_count SHALL return don't-care data.
REQ-029 O_rd_data SHALL reflect I_rd_addr/I_rd_ch sampled one cycle earlier, with 1-cycle latency, in any state.
REQ-030 O_trig_pos SHALL equal the latched trigger index converted by the REQ-027 mapping using the final write pointer and O_count.
REQ-031 A read and a write in the same cycle SHALL return the pre-write contents.
REQ-032 Storage SHALL be inferable as one simple dual-port RAM per channel or one wide RAM.

Reset
REQ-033 I_rst SHALL take priority over all inputs, including I_arm.
REQ-034 I_rst SHALL force IDLE and clear the write pointer, O_count, O_trig_pos, post counter, O_rd_data and O_done to 0.
REQ-035 Buffer RAM contents need not be cleared on reset.
REQ-036 Reset in any state, including mid-POST, SHALL abandon the capture, with O_count=0 on the following cycle.

Verification
Benches use DEPTH=8, CH=3, DATA_W=32, POST_TRIG=3.
REQ-037 Reset check: assert I_rst for 2 cycles -> O_state=0, O_count=0, O_done=0, O_rd_data=0.
REQ-038 Wrap capture: arm, trig_pc=0x20, feed PCs 0x00,0x04,...,0x2C on consecutive valid cycles -> DONE after 0x2C, O_count=8, rd 0..7 = 0x10..0x2C, O_trig_pos=4, later samples ignored.
REQ-039 Early trigger: trig_pc=0x04, feed 0x00,0x04,0x08,0x0C,0x10,0x14 -> DONE after 0x10, O_count=5, rd0=0x00, O_trig_pos=1.
REQ-040 Valid gaps and channels: interleave I_valid=0 cycles carrying junk data -> junk never stored; rd_ch=1 and rd_ch=2 return the inst and writeback values paired with each PC.
REQ-041 Force trigger and re-arm: I_force_trig on the 1st valid sample -> O_trig_pos=0; I_arm in POST ignored; I_arm in DONE -> ARMED with O_count=0.
REQ-042 Reset mid-POST: I_rst after the 1st post sample -> IDLE, O_count=0; a following arm and capture behaves exactly as REQ-038.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Retired-instruction trace buffer: circular multi-channel capture with PC-match
// or forced trigger, programmable post-trigger depth and oldest-first readout.
module cpu_trace_buffer #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CH        = 3,
    parameter int unsigned POST_TRIG = 16
) (
    input  logic                                 I_clk,
    input  logic                                 I_rst,
    input  logic                                 I_arm,
    input  logic                                 I_valid,
    input  logic [CH*DATA_W-1:0]                 I_ch_data,
    input  logic                                 I_trig_en,
    input  logic [DATA_W-1:0]                    I_trig_pc,
    input  logic                                 I_force_trig,
    input  logic [$clog2(DEPTH)-1:0]             I_rd_addr,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] I_rd_ch,
    output logic [DATA_W-1:0]                    O_rd_data,
    output logic [1:0]                           O_state,
    output logic [$clog2(DEPTH):0]               O_count,
    output logic [$clog2(DEPTH)-1:0]             O_trig_pos,
    output logic                                 O_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned WW = CH * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     w_wptr_nxt;
    logic [AW:0]       r_count;
    logic [AW:0]       w_count_nxt;
    logic [AW-1:0]     r_post_cnt;
    logic [AW-1:0]     w_post_nxt;
    logic [AW:0]       w_post_inc;
    logic [AW-1:0]     r_trig_idx;
    logic [AW-1:0]     w_trig_idx_nxt;
    logic [AW-1:0]     r_trig_pos;
    logic [AW-1:0]     w_trig_pos_nxt;
    logic              r_done;
    logic              w_we;
    logic              w_hit;
    logic [AW-1:0]     w_rd_phys;
    logic [WW-1:0]     w_rd_word;
    logic [DATA_W-1:0] w_rd_sel;
    logic [DATA_W-1:0] r_rd_data;
    logic [WW-1:0]     r_mem [DEPTH];

    assign w_hit      = I_valid & (I_force_trig |
                        (I_trig_en & (I_ch_data[DATA_W-1:0] == I_trig_pc)));
    assign w_post_inc = {1'b0, r_post_cnt} + (AW+1)'(1);

    // Next-state, pointer and counter logic
    always_comb begin
        w_state_nxt    = r_state;
        w_wptr_nxt     = r_wptr;
        w_count_nxt    = r_count;
        w_post_nxt     = r_post_cnt;
        w_trig_idx_nxt = r_trig_idx;
        w_we           = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (I_arm) begin
                    w_state_nxt = ST_ARMED;
                    w_wptr_nxt  = '0;
                    w_count_nxt = '0;
                    w_post_nxt  = '0;
                end
            end
            ST_ARMED: begin
                w_we = I_valid;
                if (w_hit) begin
                    w_trig_idx_nxt = r_wptr;
                    w_state_nxt    = (POST_TRIG == 0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                w_we = I_valid;
                if (I_valid) begin
                    w_post_nxt = w_post_inc[AW-1:0];
                    if (w_post_inc == (AW+1)'(POST_TRIG)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            default: ;
        endcase
        if (w_we) begin
            w_wptr_nxt = r_wptr + AW'(1);
            if (r_count != (AW+1)'(DEPTH)) begin
                w_count_nxt = r_count + (AW+1)'(1);
            end
        end
    end

    // Trigger index in readout order, using the pointer/count as they will be in DONE
    assign w_trig_pos_nxt = (w_count_nxt == (AW+1)'(DEPTH)) ? (w_trig_idx_nxt - w_wptr_nxt)
                                                            : w_trig_idx_nxt;

    assign w_rd_phys = (r_count == (AW+1)'(DEPTH)) ? (r_wptr + I_rd_addr) : I_rd_addr;
    assign w_rd_word = r_mem[w_rd_phys];

    always_comb begin
        w_rd_sel = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (I_rd_ch == CW'(c)) begin
                w_rd_sel = w_rd_word[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_wptr     <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_trig_idx <= '0;
            r_trig_pos <= '0;
            r_done     <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_wptr     <= w_wptr_nxt;
            r_count    <= w_count_nxt;
            r_post_cnt <= w_post_nxt;
            r_trig_idx <= w_trig_idx_nxt;
            r_done     <= (w_state_nxt == ST_DONE);
            r_rd_data  <= w_rd_sel;
            if ((r_state != ST_DONE) && (w_state_nxt == ST_DONE)) begin
                r_trig_pos <= w_trig_pos_nxt;
            end
        end
    end

    // Sample RAM: no reset so it maps onto a simple dual-port memory
    always_ff @(posedge I_clk) begin
        if (w_we && !I_rst) begin
            r_mem[r_wptr] <= I_ch_data;
        end
    end

    assign O_rd_data  = r_rd_data;
    assign O_state    = r_state;
    assign O_count    = r_count;
    assign O_trig_pos = r_trig_pos;
    assign O_done     = r_done;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer (DEPTH=8, CH=3, DATA_W=32, POST_TRIG=3);
// readout expectations go through a scoreboard queue.
module tb_cpu_trace_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        valid = 1'b0;
    logic [95:0] ch_data = '0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        force_trig = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [1:0]  rd_ch = '0;
    logic [31:0] rd_data;
    logic [1:0]  state;
    logic [3:0]  count;
    logic [2:0]  trig_pos;
    logic        done;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q [$];

    cpu_trace_buffer #(.DEPTH(8), .DATA_W(32), .CH(3), .POST_TRIG(3)) dut (
        .I_clk(clk), .I_rst(rst), .I_arm(arm), .I_valid(valid), .I_ch_data(ch_data),
        .I_trig_en(trig_en), .I_trig_pc(trig_pc), .I_force_trig(force_trig),
        .I_rd_addr(rd_addr), .I_rd_ch(rd_ch), .O_rd_data(rd_data), .O_state(state),
        .O_count(count), .O_trig_pos(trig_pos), .O_done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hE000_0000 | pc;
    endfunction

    function automatic logic [31:0] wb_of(input logic [31:0] pc);
        return 32'h5000_0000 + pc * 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] pc, input logic v, input logic f);
        valid      = v;
        force_trig = f;
        ch_data    = {wb_of(pc), inst_of(pc), pc};
        step();
        valid      = 1'b0;
        force_trig = 1'b0;
    endtask

    // Arm with a valid sample that matches the trigger: it must not be stored
    task automatic do_arm(input string tag);
        arm     = 1'b1;
        valid   = 1'b1;
        ch_data = {wb_of(trig_pc), inst_of(trig_pc), trig_pc};
        step();
        arm     = 1'b0;
        valid   = 1'b0;
        check({tag, "_arm_state"}, 32'(state), 32'd1);
        check({tag, "_arm_count"}, 32'(count), 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [1:0] c,
                          input logic [31:0] exp);
        rd_addr = a;
        rd_ch   = c;
        exp_q.push_back(exp);
        step();
        check(tag, rd_data, exp_q.pop_front());
    endtask

    task automatic run_wrap(input string tag);
        trig_en = 1'b1;
        trig_pc = 32'h20;
        do_arm(tag);
        for (int i = 0; i < 12; i++) begin
            feed(32'(i * 4), 1'b1, 1'b0);
            if (i == 10) check({tag, "_post_state"}, 32'(state), 32'd2);
        end
        check({tag, "_done_state"}, 32'(state), 32'd3);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_count"}, 32'(count), 32'd8);
        check({tag, "_trig_pos"}, 32'(trig_pos), 32'd4);
        feed(32'h30, 1'b1, 1'b0);
        feed(32'h20, 1'b1, 1'b0);
        check({tag, "_hold_count"}, 32'(count), 32'd8);
        for (int a = 0; a < 8; a++) begin
            rd_chk({tag, "_rd_pc"}, 3'(a), 2'd0, 32'h10 + 32'(a * 4));
        end
        rd_chk({tag, "_rd_inst0"}, 3'd0, 2'd1, inst_of(32'h10));
        rd_chk({tag, "_rd_wb7"}, 3'd7, 2'd2, wb_of(32'h2C));
    endtask

    initial begin
        // Reset
        step();
        step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        step();
        check("idle_hold", 32'(state), 32'd0);

        // Wrap capture from IDLE
        run_wrap("wrap");

        // Early trigger, re-armed from DONE
        trig_pc = 32'h04;
        do_arm("early");
        for (int i = 0; i < 6; i++) begin
            feed(32'(i * 4), 1'b1, 1'b0);
            if (i == 4) check("early_done_at_0x10", 32'(state), 32'd3);
        end
        check("early_count", 32'(count), 32'd5);
        check("early_trig_pos", 32'(trig_pos), 32'd1);
        for (int a = 0; a < 5; a++) begin
            rd_chk("early_rd", 3'(a), 2'd0, 32'(a * 4));
        end

        // Valid gaps with junk (including an invalid trigger-PC match)
        trig_pc = 32'h0C;
        do_arm("gaps");
        for (int i = 0; i < 7; i++) begin
            feed(32'h0C, 1'b0, 1'b1);
            feed(32'(i * 4), 1'b1, 1'b0);
        end
        check("gaps_state", 32'(state), 32'd3);
        check("gaps_count", 32'(count), 32'd7);
        check("gaps_trig_pos", 32'(trig_pos), 32'd3);
        for (int a = 0; a < 7; a++) begin
            rd_chk("gaps_pc", 3'(a), 2'd0, 32'(a * 4));
            rd_chk("gaps_inst", 3'(a), 2'd1, inst_of(32'(a * 4)));
            rd_chk("gaps_wb", 3'(a), 2'd2, wb_of(32'(a * 4)));
        end

        // Force trigger on first sample; arm ignored in POST; re-arm from DONE
        trig_en = 1'b0;
        do_arm("force");
        feed(32'h100, 1'b1, 1'b1);
        check("force_post", 32'(state), 32'd2);
        feed(32'h104, 1'b1, 1'b0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("force_arm_in_post_state", 32'(state), 32'd2);
        check("force_arm_in_post_count", 32'(count), 32'd2);
        feed(32'h108, 1'b1, 1'b0);
        feed(32'h10C, 1'b1, 1'b0);
        check("force_done", 32'(state), 32'd3);
        check("force_count", 32'(count), 32'd4);
        check("force_trig_pos", 32'(trig_pos), 32'd0);
        rd_chk("force_rd0", 3'd0, 2'd0, 32'h100);
        do_arm("rearm");
        check("rearm_done", 32'(done), 32'd0);

        // Arm ignored in ARMED, then reset mid-POST (reset beats arm)
        trig_en = 1'b1;
        trig_pc = 32'h20;
        for (int i = 0; i < 3; i++) feed(32'(i * 4), 1'b1, 1'b0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("armed_arm_ignored", 32'(count), 32'd3);
        for (int i = 3; i < 10; i++) feed(32'(i * 4), 1'b1, 1'b0);
        check("midpost_state", 32'(state), 32'd2);
        rst   = 1'b1;
        arm   = 1'b1;
        valid = 1'b1;
        step();
        rst   = 1'b0;
        arm   = 1'b0;
        valid = 1'b0;
        check("midpost_rst_state", 32'(state), 32'd0);
        check("midpost_rst_count", 32'(count), 32'd0);
        check("midpost_rst_done", 32'(done), 32'd0);
        check("midpost_rst_rd", rd_data, 32'd0);
        run_wrap("rewrap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
